instr_exec_ctrl: RTL

//  Multicycle issue/execute controller that drives the 4x16 register file.

---
 rtl/instr_exec_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/instr_exec_ctrl.sv
// Multicycle issue/execute controller for a 4x16 register file.
// One instruction per handshake: registered read, ALU, write-back; LDI writes straight from the handshake.
module instr_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_data,
    output logic              instr_ready,
    output logic              rf_read_en,
    output logic [ADR_W-1:0]  rf_read_adr1,
    output logic [ADR_W-1:0]  rf_read_adr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_en,
    output logic [ADR_W-1:0]  rf_write_adr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic              illegal_op,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic [15:6]       ir_q;  // imm8 is consumed at the handshake edge, so only op/rd/rs1/rs2 are held
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic              illegal_q;
    logic              handshake;
    logic [3:0]        hs_op;
    logic [3:0]        ir_op;
    logic [ADR_W-1:0]  ir_rd, ir_rs1, ir_rs2;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD && op <= OP_SHR) || op == OP_MOV;
    endfunction

    assign hs_op     = instr_data[15:12];
    assign handshake = instr_valid && (state_q == IDLE);
    assign ir_op     = ir_q[15:12];
    assign ir_rd     = ir_q[11:10];
    assign ir_rs1    = ir_q[9:8];
    assign ir_rs2    = ir_q[7:6];

    always_comb begin
        sum     = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
        alu_res = rf_read_data1;
        alu_c   = 1'b0;
        case (ir_op)
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = rf_read_data1 - rf_read_data2;
                alu_c   = rf_read_data1 < rf_read_data2;
            end
            OP_AND:  alu_res = rf_read_data1 & rf_read_data2;
            OP_OR:   alu_res = rf_read_data1 | rf_read_data2;
            OP_XOR:  alu_res = rf_read_data1 ^ rf_read_data2;
            OP_SHL:  alu_res = rf_read_data1 << rf_read_data2[3:0];
            OP_SHR:  alu_res = rf_read_data1 >> rf_read_data2[3:0];
            default: alu_res = rf_read_data1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        instr_ready   = 1'b0;
        rf_read_en    = 1'b0;
        rf_read_adr1  = '0;
        rf_read_adr2  = '0;
        rf_write_en   = 1'b0;
        rf_write_adr  = '0;
        rf_write_data = '0;
        done          = done_q;
        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (handshake) begin
                    if (is_alu(hs_op))         state_d = READ;
                    else if (hs_op == OP_LDI)  state_d = WB;
                    else if (hs_op == OP_HALT) state_d = HALTED;
                end
            end
            READ: begin
                rf_read_en   = 1'b1;
                rf_read_adr1 = ir_rs1;
                rf_read_adr2 = ir_rs2;
                state_d      = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                rf_write_en   = 1'b1;
                rf_write_adr  = ir_rd;
                rf_write_data = result_q;
                done          = 1'b1;
                state_d       = IDLE;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            result_q  <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (handshake) begin
                ir_q <= instr_data[15:6];
                if (hs_op == OP_LDI) begin
                    result_q <= DATA_W'(instr_data[7:0]);
                    flag_z   <= (instr_data[7:0] == 8'h00);
                    flag_c   <= 1'b0;
                end else if (hs_op == OP_NOP || hs_op == OP_HALT) begin
                    done_q <= 1'b1;
                end else if (!is_alu(hs_op)) begin
                    done_q    <= 1'b1;
                    illegal_q <= 1'b1;
                end
            end
            // Flags move only when a write-back is guaranteed to follow.
            if (state_q == EXEC) begin
                result_q <= alu_res;
                flag_z   <= (alu_res == '0);
                flag_c   <= alu_c;
            end
        end
    end

    assign illegal_op = illegal_q;
    assign halted     = (state_q == HALTED);
    assign state_dbg  = state_q;

endmodule
